// File: rtl/pool_sum.sv
// Pooling stage after pow: sums every POOL_SIZE accepted samples and emits the
// saturated sum, or the floor-mean when AVERAGE=1, through a valid/ready pair.
module pool_sum #(
    parameter int DATA_WIDTH = 32,
    parameter int FRACTION   = 24,
    parameter int POOL_SIZE  = 4,
    parameter int AVERAGE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  pool_ready_in,
    input  logic [DATA_WIDTH-1:0] pool_data_in,
    input  logic                  pool_valid_in,
    input  logic                  pool_ready_out,
    output logic [DATA_WIDTH-1:0] pool_data_out,
    output logic                  pool_valid_out
);

    localparam int LOG2  = $clog2(POOL_SIZE);
    localparam int ACC_W = DATA_WIDTH + LOG2;

    // Fixed-point format passes straight through: sums and shifts need no rescale.
    localparam int fraction_unused = FRACTION;

    localparam logic [LOG2-1:0] CNT_LAST = LOG2'(POOL_SIZE - 1);

    localparam logic signed [ACC_W-1:0] SUM_MAX =
        {{(LOG2 + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN =
        {{(LOG2 + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic [LOG2-1:0]          cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  scaled;
    logic [DATA_WIDTH-1:0]    sat;
    logic                     is_last;
    logic                     take_in;
    logic                     load_out;

    // Handshake: a beat moves on a side only in a cycle where valid && ready are
    // both high. pool_ready_in depends on registered state and pool_ready_out only,
    // and drops solely when the window's final beat would overwrite a stalled result.
    assign is_last       = (cnt == CNT_LAST);
    assign pool_ready_in = !(is_last && pool_valid_out && !pool_ready_out);
    assign take_in       = pool_valid_in && pool_ready_in;
    assign load_out      = take_in && is_last;

    always_comb begin
        sum = acc + {{LOG2{pool_data_in[DATA_WIDTH-1]}}, pool_data_in};
        if (AVERAGE != 0) begin
            scaled = sum >>> LOG2;
        end else begin
            scaled = sum;
        end
        if (scaled > SUM_MAX) begin
            sat = OUT_MAX;
        end else if (scaled < SUM_MIN) begin
            sat = OUT_MIN;
        end else begin
            sat = scaled[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            acc            <= '0;
            pool_valid_out <= 1'b0;
            pool_data_out  <= '0;
        end else begin
            if (take_in) begin
                if (is_last) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + LOG2'(1);
                    acc <= sum;
                end
            end
            // A new result and a consume in the same cycle keep valid high.
            if (load_out) begin
                pool_data_out  <= sat;
                pool_valid_out <= 1'b1;
            end else if (pool_valid_out && pool_ready_out) begin
                pool_valid_out <= 1'b0;
            end
        end
    end

endmodule
